// File: rtl/lru_replacement_multiset.sv
// lru_replacement_multiset
// Registered true-LRU replacement engine covering every set of a
// set-associative cache. Each set keeps an LRU->MRU stack of way indices plus
// a per-way valid vector. Victim selection prefers the lowest-numbered invalid
// way and falls back to the LRU way. A sequenced flush walks one set per cycle.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   touch_valid_i/set_i/way_i          hit or fill: way becomes MRU and valid
//   inval_i/inval_set_i/inval_way_i    invalidate: way becomes LRU and invalid
//   victim_req_i/victim_set_i          victim query, answered one cycle later
//   flush_i                            start whole-cache flush (pulse)
//   victim_valid_o/victim_way_o        registered victim response
//   busy_o                             flush in progress, requests ignored
module lru_replacement_multiset #(
   parameter int num_sets      = 16,
   parameter int associativity = 4,
   parameter int set_wid       = $clog2(num_sets),
   parameter int way_wid       = $clog2(associativity)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               touch_valid_i,
   input  logic [set_wid-1:0] touch_set_i,
   input  logic [way_wid-1:0] touch_way_i,
   input  logic               inval_i,
   input  logic [set_wid-1:0] inval_set_i,
   input  logic [way_wid-1:0] inval_way_i,
   input  logic               victim_req_i,
   input  logic [set_wid-1:0] victim_set_i,
   input  logic               flush_i,
   output logic               victim_valid_o,
   output logic [way_wid-1:0] victim_way_o,
   output logic               busy_o
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t             state_r, state_next_s;
   logic [set_wid-1:0] cnt_r, cnt_next_s;
   logic               busy_r;
   logic               victim_valid_r;
   logic [way_wid-1:0] victim_way_r;

   logic [way_wid-1:0]       order_r [num_sets][associativity];
   logic [associativity-1:0] valid_r [num_sets];

   logic               idle_s;
   logic               touch_ok_s;
   logic               inval_ok_s;
   logic [way_wid-1:0] touch_order_s [associativity];
   logic [way_wid-1:0] inval_order_s [associativity];
   logic [way_wid-1:0] victim_s;

   // A way index is only usable when it names an existing way; this matters
   // when associativity is not a power of two.
   function automatic logic way_in_range(input logic [way_wid-1:0] w);
      return (int'(w) < associativity);
   endfunction

   // Requests are only accepted in IDLE, and flush_i wins over all of them.
   assign idle_s     = (state_r == ST_IDLE) && !flush_i;
   assign inval_ok_s = idle_s && inval_i && way_in_range(inval_way_i);
   // An invalidate to the same set suppresses the touch regardless of way.
   assign touch_ok_s = idle_s && touch_valid_i && way_in_range(touch_way_i) &&
                       !(inval_ok_s && (inval_set_i == touch_set_i));

   // Flush sequencer next-state: walk sets 0..num_sets-1, one per cycle.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            cnt_next_s = {set_wid{1'b0}};
            if (flush_i) begin
               state_next_s = ST_FLUSH;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (cnt_r == set_wid'(num_sets - 1)) begin
               state_next_s = ST_IDLE;
               cnt_next_s   = {set_wid{1'b0}};
            end else begin
               state_next_s = ST_FLUSH;
               cnt_next_s   = cnt_r + set_wid'(1);
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {set_wid{1'b0}};
         end
      endcase
   end

   // Touch: everything above the touched way's position slides down one slot
   // and the touched way lands in the MRU slot. hit_v marks positions at or
   // above the match, so touching the MRU way leaves the stack untouched.
   always_comb begin
      logic hit_v;
      hit_v         = 1'b0;
      touch_order_s = order_r[touch_set_i];
      for (int k = 0; k < associativity - 1; k++) begin
         hit_v = hit_v | (order_r[touch_set_i][k] == touch_way_i);
         touch_order_s[k] = hit_v ? order_r[touch_set_i][k+1] : order_r[touch_set_i][k];
      end
      touch_order_s[associativity-1] = touch_way_i;
   end

   // Invalidate: everything below the way's position slides up one slot and
   // the way lands in the LRU slot. Scanning from MRU downward, hit_v marks
   // positions at or below the match.
   always_comb begin
      logic hit_v;
      hit_v         = 1'b0;
      inval_order_s = order_r[inval_set_i];
      for (int k = associativity - 1; k > 0; k--) begin
         hit_v = hit_v | (order_r[inval_set_i][k] == inval_way_i);
         inval_order_s[k] = hit_v ? order_r[inval_set_i][k-1] : order_r[inval_set_i][k];
      end
      inval_order_s[0] = inval_way_i;
   end

   // Victim pick on pre-update state: the lowest invalid way wins (scan runs
   // high to low so the last hit is the lowest), otherwise the LRU way.
   always_comb begin
      victim_s = order_r[victim_set_i][0];
      for (int k = associativity - 1; k >= 0; k--) begin
         victim_s = valid_r[victim_set_i][k] ? victim_s : way_wid'(k);
      end
   end

   // Sequencer state, flush set counter and busy flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= {set_wid{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         busy_r  <= (state_next_s == ST_FLUSH);
      end
   end

   // Victim response register; the way holds its value between responses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         victim_valid_r <= 1'b0;
         victim_way_r   <= {way_wid{1'b0}};
      end else begin
         victim_valid_r <= idle_s && victim_req_i;
         if (idle_s && victim_req_i) begin
            victim_way_r <= victim_s;
         end else begin
            victim_way_r <= victim_way_r;
         end
      end
   end

   // Per-set LRU stacks and valid vectors. The flush rewrites one set per
   // cycle; otherwise the accepted invalidate and touch update their sets
   // (they never target the same set in one cycle).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < num_sets; s++) begin
            for (int k = 0; k < associativity; k++) begin
               order_r[s][k] <= way_wid'(k);
            end
            valid_r[s] <= {associativity{1'b0}};
         end
      end else if (state_r == ST_FLUSH) begin
         for (int k = 0; k < associativity; k++) begin
            order_r[cnt_r][k] <= way_wid'(k);
         end
         valid_r[cnt_r] <= {associativity{1'b0}};
      end else begin
         if (inval_ok_s) begin
            for (int k = 0; k < associativity; k++) begin
               order_r[inval_set_i][k] <= inval_order_s[k];
            end
            valid_r[inval_set_i][inval_way_i] <= 1'b0;
         end
         if (touch_ok_s) begin
            for (int k = 0; k < associativity; k++) begin
               order_r[touch_set_i][k] <= touch_order_s[k];
            end
            valid_r[touch_set_i][touch_way_i] <= 1'b1;
         end
      end
   end

   assign victim_valid_o = victim_valid_r;
   assign victim_way_o   = victim_way_r;
   assign busy_o         = busy_r;

endmodule

// File: tb/tb_lru_replacement_multiset.sv
// tb_lru_replacement_multiset
// Self-checking bench for lru_replacement_multiset (16 sets, 4 ways).
// A hand-computed vector table covers the directed scenarios, hand-written
// sequences cover flush and reset-during-flush, and a random phase compares
// against a queue-based reference model of each set's LRU stack.
module tb_lru_replacement_multiset;

   localparam int NS = 16;
   localparam int NA = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       touch_valid = 1'b0;
   logic [3:0] touch_set = 4'd0;
   logic [1:0] touch_way = 2'd0;
   logic       inval = 1'b0;
   logic [3:0] inval_set = 4'd0;
   logic [1:0] inval_way = 2'd0;
   logic       victim_req = 1'b0;
   logic [3:0] victim_set = 4'd0;
   logic       flush = 1'b0;
   logic       victim_valid;
   logic [1:0] victim_way;
   logic       busy;

   int compared = 0;
   int mismatched = 0;
   int last_w = 0;

   // Reference model: LRU->MRU queue per set plus valid bits.
   int ord_m [NS][$];
   bit [NA-1:0] val_m [NS];

   lru_replacement_multiset #(.num_sets(NS), .associativity(NA)) dut (
      .clk_i(clk), .rst_i(rst),
      .touch_valid_i(touch_valid), .touch_set_i(touch_set), .touch_way_i(touch_way),
      .inval_i(inval), .inval_set_i(inval_set), .inval_way_i(inval_way),
      .victim_req_i(victim_req), .victim_set_i(victim_set), .flush_i(flush),
      .victim_valid_o(victim_valid), .victim_way_o(victim_way), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit tv; int ts; int tw;
      bit iv; int is; int iw;
      bit vr; int vs;
      bit ev; int ew;
   } vec_t;

   vec_t tbl [26];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int s = 0; s < NS; s++) begin
         ord_m[s].delete();
         for (int k = 0; k < NA; k++) ord_m[s].push_back(k);
         val_m[s] = '0;
      end
   endtask

   function automatic int m_find(int s, int w);
      int idx;
      idx = 0;
      for (int k = 0; k < NA; k++) if (ord_m[s][k] == w) idx = k;
      return idx;
   endfunction

   task automatic m_touch(int s, int w);
      ord_m[s].delete(m_find(s, w));
      ord_m[s].push_back(w);
      val_m[s][w] = 1'b1;
   endtask

   task automatic m_inval(int s, int w);
      ord_m[s].delete(m_find(s, w));
      ord_m[s].push_front(w);
      val_m[s][w] = 1'b0;
   endtask

   function automatic int m_victim(int s);
      int v;
      bit found;
      v = ord_m[s][0];
      found = 1'b0;
      for (int k = 0; k < NA; k++) begin
         if (!found && !val_m[s][k]) begin
            v = k;
            found = 1'b1;
         end
      end
      return v;
   endfunction

   task automatic clear_inputs();
      touch_valid = 1'b0; inval = 1'b0; victim_req = 1'b0; flush = 1'b0;
   endtask

   // Drives one IDLE cycle, advances the model, returns the expected response.
   task automatic drive(input bit tv, input int ts, input int tw, input bit iv,
                        input int is, input int iw, input bit vr, input int vs,
                        output bit ev, output int ew);
      touch_valid = tv; touch_set = ts[3:0]; touch_way = tw[1:0];
      inval = iv; inval_set = is[3:0]; inval_way = iw[1:0];
      victim_req = vr; victim_set = vs[3:0]; flush = 1'b0;
      ev = vr;
      ew = vr ? m_victim(vs) : last_w;
      if (iv) m_inval(is, iw);
      if (tv && !(iv && is == ts)) m_touch(ts, tw);
      last_w = ew;
      @(posedge clk); #1;
      clear_inputs();
   endtask

   initial begin
      bit ev;
      int ew;

      tbl[0]  = '{0,0,0, 0,0,0, 1,3, 1,0};
      tbl[1]  = '{1,5,0, 0,0,0, 0,0, 0,0};
      tbl[2]  = '{1,5,1, 0,0,0, 0,0, 0,0};
      tbl[3]  = '{1,5,2, 0,0,0, 0,0, 0,0};
      tbl[4]  = '{1,5,3, 0,0,0, 0,0, 0,0};
      tbl[5]  = '{0,0,0, 0,0,0, 1,5, 1,0};
      tbl[6]  = '{1,5,0, 0,0,0, 0,0, 0,0};
      tbl[7]  = '{0,0,0, 0,0,0, 1,5, 1,1};
      tbl[8]  = '{1,5,2, 0,0,0, 0,0, 0,1};
      tbl[9]  = '{0,0,0, 0,0,0, 1,5, 1,1};
      tbl[10] = '{0,0,0, 1,5,0, 0,0, 0,1};
      tbl[11] = '{0,0,0, 0,0,0, 1,5, 1,0};
      tbl[12] = '{1,5,0, 0,0,0, 0,0, 0,0};
      tbl[13] = '{0,0,0, 0,0,0, 1,5, 1,1};
      tbl[14] = '{1,2,0, 0,0,0, 0,0, 0,1};
      tbl[15] = '{1,2,1, 0,0,0, 0,0, 0,1};
      tbl[16] = '{1,2,2, 0,0,0, 0,0, 0,1};
      tbl[17] = '{1,2,3, 0,0,0, 0,0, 0,1};
      tbl[18] = '{1,2,1, 1,2,1, 1,2, 1,0};
      tbl[19] = '{0,0,0, 0,0,0, 1,2, 1,1};
      tbl[20] = '{1,6,0, 1,7,3, 0,0, 0,1};
      tbl[21] = '{0,0,0, 0,0,0, 1,6, 1,1};
      tbl[22] = '{0,0,0, 0,0,0, 1,7, 1,0};
      tbl[23] = '{1,5,1, 1,5,3, 0,0, 0,0};
      tbl[24] = '{1,5,3, 0,0,0, 0,0, 0,0};
      tbl[25] = '{0,0,0, 0,0,0, 1,5, 1,1};

      m_reset();
      #12;
      check("reset_busy", busy, 1'b0);
      check("reset_vvalid", victim_valid, 1'b0);
      check("reset_vway", victim_way, 2'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].tv, tbl[i].ts, tbl[i].tw, tbl[i].iv, tbl[i].is, tbl[i].iw,
               tbl[i].vr, tbl[i].vs, ev, ew);
         check($sformatf("tbl%0d_valid", i), victim_valid, tbl[i].ev);
         check($sformatf("tbl%0d_way", i), victim_way, tbl[i].ew);
         check($sformatf("tbl%0d_busy", i), busy, 1'b0);
      end

      // Fill every set, then flush with requests and a repeated flush_i.
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < NA; k++)
            drive(1'b1, s, (s + k) % NA, 1'b0, 0, 0, 1'b0, 0, ev, ew);
      flush = 1'b1; victim_req = 1'b1; victim_set = 4'd0;
      touch_valid = 1'b1; touch_set = 4'd1; touch_way = 2'd0;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy_start", busy, 1'b1);
      check("flush_pending_vvalid", victim_valid, 1'b0);
      for (int i = 2; i <= 16; i++) begin
         victim_req = 1'b1; victim_set = 4'(i);
         touch_valid = 1'b1; touch_set = 4'(i); touch_way = 2'(i);
         inval = 1'b1; inval_set = 4'(i + 3); inval_way = 2'(i + 1);
         flush = (i == 5);
         @(posedge clk); #1;
         check($sformatf("flush_busy_%0d", i), busy, 1'b1);
         check($sformatf("flush_vvalid_%0d", i), victim_valid, 1'b0);
      end
      victim_req = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      clear_inputs();
      check("flush_busy_end", busy, 1'b0);
      check("flush_last_vvalid", victim_valid, 1'b0);
      check("flush_way_hold", victim_way, last_w);
      m_reset();
      for (int s = 0; s < NS; s++) begin
         drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, s, ev, ew);
         check($sformatf("postflush_way_s%0d", s), victim_way, 0);
         check($sformatf("postflush_model_s%0d", s), victim_way, ew);
         drive(1'b1, s, 0, 1'b0, 0, 0, 1'b1, s, ev, ew);
         drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, s, ev, ew);
         check($sformatf("postflush_inv_s%0d", s), victim_way, 1);
      end

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         int ts, is, vs;
         ts = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 3);
         is = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 3);
         vs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NS - 1) : $urandom_range(0, 3);
         drive($urandom_range(0, 99) < 60, ts, $urandom_range(0, NA - 1),
               $urandom_range(0, 99) < 20, is, $urandom_range(0, NA - 1),
               $urandom_range(0, 1) == 1, vs, ev, ew);
         check("rnd_vvalid", victim_valid, ev);
         check("rnd_vway", victim_way, ew);
         check("rnd_busy", busy, 1'b0);
      end

      // Asynchronous reset while the flush counter is at 7.
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; victim_req = 1'b1; victim_set = 4'd2;
      repeat (7) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_vvalid", victim_valid, 1'b0);
      check("abort_vway", victim_way, 2'd0);
      clear_inputs();
      @(negedge clk); rst = 1'b0;
      m_reset();
      last_w = 0;
      @(posedge clk); #1;
      for (int s = 0; s < NS; s++) begin
         drive(1'b1, s, 2, 1'b0, 0, 0, 1'b1, s, ev, ew);
         check($sformatf("abort_pre_s%0d", s), victim_way, 0);
         drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, s, ev, ew);
         check($sformatf("abort_post_s%0d", s), victim_way, ew);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lru_replacement_multiset.md
Name: lru_replacement_multiset

Overview:
Registered, multi-set true-LRU replacement engine for the set-associative cache: one LRU stack and one per-way valid vector per set. It supersedes the single-set combinational shift-register LRU. It accepts touch (hit/fill), invalidate and victim-query requests from the cache controller, and adds invalid-way-first victim selection. It also provides a sequenced whole-cache flush.

Parameters:
num_sets, 16, number of cache sets (power of two, >=2)
associativity, 4, ways per set (>=2)
set_wid, $clog2(num_sets), set index width
way_wid, $clog2(associativity), way index width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
touch_valid_i  in  1  access/fill on touch_set_i, touch_way_i
touch_set_i  in  set_wid  set being touched
touch_way_i  in  way_wid  way being touched
inval_i  in  1  invalidate one way
inval_set_i  in  set_wid  set to invalidate
inval_way_i  in  way_wid  way to invalidate
victim_req_i  in  1  victim query for victim_set_i
victim_set_i  in  set_wid  set being queried
flush_i  in  1  start whole-cache flush (pulse)
victim_valid_o  out  1  victim_way_o valid this cycle
victim_way_o  out  way_wid  selected victim way
busy_o  out  1  flush in progress, requests ignored

Behaviour:
- State per set: order[0..associativity-1] of way indices, where order[0] is LRU and order[associativity-1] is MRU. Also a valid[associativity-1:0] vector.
- Reset (async, any time): every set gets order[k]=k and valid=0. FSM goes to IDLE; victim_valid_o=0, victim_way_o=0, busy_o=0.
- Touch (IDLE, touch_valid_i=1):
  - Way w is found at position p in the set's order.
  - Entries p+1..associativity-1 shift down by one; w goes to MRU; valid[w]=1.
  - Touching the current MRU leaves order unchanged.
  - The update is visible from the next cycle.
- Invalidate (IDLE, inval_i=1):
  - Way w at position p: entries 0..p-1 shift up by one; w goes to order[0]; valid[w]=0.
  - Invalidating an already-invalid way still moves it to LRU.
- Victim query (IDLE, victim_req_i=1):
  - Response is registered with 1-cycle latency: victim_valid_o=1 on the next cycle for exactly one cycle per request.
  - victim_way_o is the lowest-numbered way with valid=0 if any exists, else order[0].
  - Back-to-back requests give back-to-back responses.
  - A query never modifies state; the controller touches the filled way afterwards.
  - victim_way_o holds its last value when victim_valid_o=0.
- Simultaneous events, same cycle:
  - Victim query is evaluated on pre-update state of this cycle's touch/inval.
  - Touch and inval to different sets: both applied.
  - Touch and inval to the same set: only inval applied, touch dropped, regardless of way.
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH on flush_i=1. flush_i has priority over any touch, inval or victim request that cycle; those are dropped.
  - In FLUSH: a set counter starts at 0 and increments each cycle. Each cycle set[counter] gets order[k]=k and valid=0. busy_o=1 from the cycle after flush_i through the final set's cycle.
  - After set num_sets-1 is written, return to IDLE. Flush takes exactly num_sets cycles.
  - flush_i during FLUSH is ignored; the counter does not restart.
  - All touch, inval and victim requests during FLUSH are ignored; victim_valid_o=0.
  - A victim response already pending from the flush_i cycle is suppressed.
- Out-of-range way index (associativity not a power of two, index >= associativity): the request is ignored, no state change.
- Reset during FLUSH aborts the sequence; the end state is identical to full reset.

Test Plan:
- After reset, victim_req set 3 -> next cycle victim_valid_o=1, victim_way_o=0; busy_o=0.
- Set 5: touch ways 0,1,2,3, then victim_req -> way 0; touch 0, victim_req -> way 1; touch 2, victim_req -> way 1.
- Set 5 all valid, order LRU->MRU 1,3,0,2; inval way 0 -> victim_req returns 0 (invalid-first); touch 0 -> victim_req returns 1.
- Same cycle: touch set 2 way 1 and inval set 2 way 1 -> way 1 invalid and at LRU; victim_req set 2 in that same cycle returns the pre-update victim.
- Fill all 16 sets; pulse flush_i -> busy_o high 16 cycles; victim_req during busy -> no victim_valid_o; after busy_o falls, every set victim = way 0 with all ways invalid.
- Assert rst_i asynchronously mid-flush (counter=7) -> busy_o drops immediately, victim_valid_o=0; all sets at identity order, valid=0.
